// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 decode encodings and pipeline bubble constants
package riscv_pkg;

   localparam logic [1:0] RESULT_ALU = 2'b00;
   localparam logic [1:0] RESULT_MEM = 2'b01;
   localparam logic [1:0] RESULT_PC4 = 2'b10;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic       valid;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       alu_src;
      logic [1:0] result_src;
      logic [2:0] alu_control;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // Bubble shared by IF/ID, ID/EX and EX/MEM: no valid bit, no side effects.
   localparam ctrl_t CTRL_BUBBLE = ctrl_t'(0);

   function automatic ctrl_t gate_side_effects(input ctrl_t c);
      ctrl_t g;
      g = c;
      if (!c.valid) begin
         g.reg_write = 1'b0;
         g.mem_write = 1'b0;
         g.branch    = 1'b0;
         g.jump      = 1'b0;
      end
      return g;
   endfunction

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic pipeline register with async clear, sync clear and enable
module pipe_reg #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= CLR_VAL;
      else if (clear)
         q <= CLR_VAL;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register; ID_EX_PERF_EN adds bubble/stall counters
import riscv_pkg::*;

module id_ex_register #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall_e,
   input  logic                  flush_e,
   input  logic                  valid_d,
   input  logic                  reg_write_d,
   input  logic                  mem_write_d,
   input  logic                  branch_d,
   input  logic                  jump_d,
   input  logic                  alu_src_d,
   input  logic [1:0]            result_src_d,
   input  logic [2:0]            alu_control_d,
   input  logic [XLEN-1:0]       rd1_d,
   input  logic [XLEN-1:0]       rd2_d,
   input  logic [XLEN-1:0]       pc_d,
   input  logic [XLEN-1:0]       imm_ext_d,
   input  logic [XLEN-1:0]       pc_plus4_d,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rd_d,
   output logic                  valid_e,
   output logic                  reg_write_e,
   output logic                  mem_write_e,
   output logic                  branch_e,
   output logic                  jump_e,
   output logic                  alu_src_e,
   output logic [1:0]            result_src_e,
   output logic [2:0]            alu_control_e,
   output logic [XLEN-1:0]       rd1_e,
   output logic [XLEN-1:0]       rd2_e,
   output logic [XLEN-1:0]       pc_e,
   output logic [XLEN-1:0]       imm_ext_e,
   output logic [XLEN-1:0]       pc_plus4_e,
   output logic [REG_ADDR_W-1:0] rs1_e,
   output logic [REG_ADDR_W-1:0] rs2_e,
   output logic [REG_ADDR_W-1:0] rd_e
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]           bubble_count_e,
   output logic [31:0]           stall_count_e
`endif
);

   localparam int DATA_W = 5 * XLEN;
   localparam int IDX_W  = 3 * REG_ADDR_W;

   ctrl_t              ctrl_raw;
   ctrl_t              ctrl_d;
   ctrl_t              ctrl_q;
   logic [DATA_W-1:0]  data_d;
   logic [DATA_W-1:0]  data_q;
   logic [IDX_W-1:0]   idx_d;
   logic [IDX_W-1:0]   idx_q;
   logic               load_en;

   // Flush wins over stall because pipe_reg evaluates clear before enable.
   assign load_en = !stall_e;

   always_comb begin
      ctrl_raw             = CTRL_BUBBLE;
      ctrl_raw.valid       = valid_d;
      ctrl_raw.reg_write   = reg_write_d;
      ctrl_raw.mem_write   = mem_write_d;
      ctrl_raw.branch      = branch_d;
      ctrl_raw.jump        = jump_d;
      ctrl_raw.alu_src     = alu_src_d;
      ctrl_raw.result_src  = result_src_d;
      ctrl_raw.alu_control = alu_control_d;
   end

   // An invalid slot never reaches reg_write/mem_write/branch/jump, so rd_e can't commit.
   assign ctrl_d = gate_side_effects(ctrl_raw);
   assign data_d = {rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus4_d};
   assign idx_d  = {rs1_d, rs2_d, rd_d};

   pipe_reg #(.WIDTH(CTRL_W), .CLR_VAL(CTRL_BUBBLE)) u_ctrl_reg (
      .clk   (clk),
      .reset (reset),
      .clear (flush_e),
      .en    (load_en),
      .d     (ctrl_d),
      .q     (ctrl_q)
   );

   pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
      .clk   (clk),
      .reset (reset),
      .clear (flush_e),
      .en    (load_en),
      .d     (data_d),
      .q     (data_q)
   );

   pipe_reg #(.WIDTH(IDX_W)) u_idx_reg (
      .clk   (clk),
      .reset (reset),
      .clear (flush_e),
      .en    (load_en),
      .d     (idx_d),
      .q     (idx_q)
   );

   assign valid_e       = ctrl_q.valid;
   assign reg_write_e   = ctrl_q.reg_write;
   assign mem_write_e   = ctrl_q.mem_write;
   assign branch_e      = ctrl_q.branch;
   assign jump_e        = ctrl_q.jump;
   assign alu_src_e     = ctrl_q.alu_src;
   assign result_src_e  = ctrl_q.result_src;
   assign alu_control_e = ctrl_q.alu_control;

   assign {rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e} = data_q;
   assign {rs1_e, rs2_e, rd_e}                        = idx_q;

`ifdef ID_EX_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_count_e <= '0;
         stall_count_e  <= '0;
      end else begin
         if (flush_e && (bubble_count_e != 32'hFFFF_FFFF))
            bubble_count_e <= bubble_count_e + 32'd1;
         if (!flush_e && stall_e && (stall_count_e != 32'hFFFF_FFFF))
            stall_count_e <= stall_count_e + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - directed self-checking bench for id_ex_register
`timescale 1ns/1ps
module tb_id_ex_register;

   logic        clk = 1'b0;
   logic        reset, stall_e, flush_e, valid_d;
   logic        reg_write_d, mem_write_d, branch_d, jump_d, alu_src_d;
   logic [1:0]  result_src_d;
   logic [2:0]  alu_control_d;
   logic [31:0] rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus4_d;
   logic [4:0]  rs1_d, rs2_d, rd_d;
   logic        valid_e, reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e;
   logic [1:0]  result_src_e;
   logic [2:0]  alu_control_e;
   logic [31:0] rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e;
   logic [4:0]  rs1_e, rs2_e, rd_e;
`ifdef ID_EX_PERF_EN
   logic [31:0] bubble_count_e, stall_count_e;
   logic [31:0] b0, s0;
`endif

   int errors = 0;
   int checks = 0;

   wire [185:0] all_e = {valid_e, reg_write_e, mem_write_e, branch_e, jump_e, alu_src_e,
                         result_src_e, alu_control_e, rd1_e, rd2_e, pc_e, imm_ext_e,
                         pc_plus4_e, rs1_e, rs2_e, rd_e};

   always #5 clk = ~clk;

   id_ex_register #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
      .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .branch_d(branch_d),
      .jump_d(jump_d), .alu_src_d(alu_src_d), .result_src_d(result_src_d),
      .alu_control_d(alu_control_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d),
      .imm_ext_d(imm_ext_d), .pc_plus4_d(pc_plus4_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
      .rd_d(rd_d), .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
      .branch_e(branch_e), .jump_e(jump_e), .alu_src_e(alu_src_e),
      .result_src_e(result_src_e), .alu_control_e(alu_control_e), .rd1_e(rd1_e),
      .rd2_e(rd2_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e), .pc_plus4_e(pc_plus4_e),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
`ifdef ID_EX_PERF_EN
      , .bubble_count_e(bubble_count_e), .stall_count_e(stall_count_e)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_d(input logic v, input logic rw, input logic mw, input logic br,
                        input logic jp, input logic as, input logic [1:0] rs,
                        input logic [2:0] ac, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] pc4,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
      valid_d = v; reg_write_d = rw; mem_write_d = mw; branch_d = br; jump_d = jp;
      alu_src_d = as; result_src_d = rs; alu_control_d = ac;
      rd1_d = r1; rd2_d = r2; pc_d = pc; imm_ext_d = imm; pc_plus4_d = pc4;
      rs1_d = s1; rs2_d = s2; rd_d = d;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
      set_d(1, 1, 1, 1, 1, 1, 2'b10, 3'b011, 32'h1111, 32'h2222, 32'h3333, 32'h4444,
            32'h5555, 5'd1, 5'd2, 5'd3);
      step();
      checks++;
      if (all_e !== '0) begin
         errors++; $display("FAIL reset_hold all_e got %h want 0", all_e);
      end
`ifdef ID_EX_PERF_EN
      checks++;
      if (bubble_count_e !== 32'd0 || stall_count_e !== 32'd0) begin
         errors++; $display("FAIL reset_counters got %h/%h want 0/0", bubble_count_e, stall_count_e);
      end
`endif
      reset = 1'b0;
   endtask

   task automatic test_capture_lw();
      set_d(1, 1, 0, 0, 0, 1, 2'b01, 3'b000, 32'h1000, 32'h0, 32'h40, 32'd4, 32'h44,
            5'd2, 5'd0, 5'd5);
      step();
      checks++;
      if ({valid_e, reg_write_e, mem_write_e, alu_src_e, result_src_e, alu_control_e} !== 9'b1_1_0_1_01_000) begin
         errors++; $display("FAIL lw_ctrl got %b%b%b%b%b%b want 110101000", valid_e, reg_write_e,
                            mem_write_e, alu_src_e, result_src_e, alu_control_e);
      end
      checks++;
      if (rd1_e !== 32'h1000 || imm_ext_e !== 32'd4) begin
         errors++; $display("FAIL lw_data got rd1=%h imm=%h want 1000/4", rd1_e, imm_ext_e);
      end
      checks++;
      if (rd_e !== 5'd5 || rs1_e !== 5'd2 || pc_plus4_e !== 32'h44) begin
         errors++; $display("FAIL lw_idx got rd=%0d rs1=%0d pc4=%h want 5/2/44", rd_e, rs1_e, pc_plus4_e);
      end
   endtask

   task automatic test_stall();
      set_d(1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 32'd7, 32'd9, 32'h48, 32'd0, 32'h4C,
            5'd1, 5'd2, 5'd3);
      step();
`ifdef ID_EX_PERF_EN
      s0 = stall_count_e;
`endif
      stall_e = 1'b1;
      set_d(1, 0, 1, 1, 1, 1, 2'b10, 3'b011, 32'hDEAD, 32'hBEEF, 32'h99, 32'h77, 32'h9D,
            5'd9, 5'd10, 5'd11);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (rd_e !== 5'd3 || reg_write_e !== 1'b1 || mem_write_e !== 1'b0 ||
             rd1_e !== 32'd7 || rd2_e !== 32'd9 || pc_e !== 32'h48) begin
            errors++; $display("FAIL stall_hold cycle %0d got rd=%0d rw=%b mw=%b rd1=%h rd2=%h pc=%h want 3/1/0/7/9/48",
                               i, rd_e, reg_write_e, mem_write_e, rd1_e, rd2_e, pc_e);
         end
      end
`ifdef ID_EX_PERF_EN
      checks++;
      if (stall_count_e - s0 !== 32'd3) begin
         errors++; $display("FAIL stall_count got delta %0d want 3", stall_count_e - s0);
      end
`endif
      stall_e = 1'b0;
   endtask

   task automatic test_flush_priority();
      set_d(1, 0, 1, 0, 0, 1, 2'b00, 3'b000, 32'h2000, 32'hAB, 32'h50, 32'd8, 32'h54,
            5'd4, 5'd6, 5'd0);
      step();
      checks++;
      if (mem_write_e !== 1'b1 || rd2_e !== 32'hAB) begin
         errors++; $display("FAIL sw_capture got mw=%b rd2=%h want 1/ab", mem_write_e, rd2_e);
      end
`ifdef ID_EX_PERF_EN
      b0 = bubble_count_e; s0 = stall_count_e;
`endif
      flush_e = 1'b1; stall_e = 1'b1;
      step();
      checks++;
      if (mem_write_e !== 1'b0 || valid_e !== 1'b0) begin
         errors++; $display("FAIL flush_prio got mw=%b valid=%b want 0/0", mem_write_e, valid_e);
      end
      checks++;
      if (all_e !== '0) begin
         errors++; $display("FAIL flush_bubble all_e got %h want 0", all_e);
      end
`ifdef ID_EX_PERF_EN
      checks++;
      if (bubble_count_e - b0 !== 32'd1 || stall_count_e !== s0) begin
         errors++; $display("FAIL flush_counters got bubble delta %0d stall %0d want 1/%0d",
                            bubble_count_e - b0, stall_count_e, s0);
      end
`endif
      flush_e = 1'b0; stall_e = 1'b0;
   endtask

   task automatic test_invalid();
      set_d(0, 0, 0, 1, 0, 0, 2'b00, 3'b001, 32'd5, 32'd5, 32'h60, 32'h10, 32'h64,
            5'd1, 5'd2, 5'd0);
      step();
      checks++;
      if (branch_e !== 1'b0 || alu_control_e !== 3'b001 || valid_e !== 1'b0 || pc_e !== 32'h60) begin
         errors++; $display("FAIL invalid_beq got br=%b alu=%b valid=%b pc=%h want 0/001/0/60",
                            branch_e, alu_control_e, valid_e, pc_e);
      end
      set_d(0, 1, 1, 1, 1, 1, 2'b10, 3'b101, 32'h1, 32'h2, 32'h70, 32'h3, 32'h74,
            5'd8, 5'd9, 5'd7);
      step();
      checks++;
      if ({reg_write_e, mem_write_e, branch_e, jump_e} !== 4'b0000 || rd_e !== 5'd7 ||
          alu_src_e !== 1'b1 || result_src_e !== 2'b10) begin
         errors++; $display("FAIL invalid_gate got rw/mw/br/jp=%b%b%b%b rd=%0d as=%b rs=%b want 0000/7/1/10",
                            reg_write_e, mem_write_e, branch_e, jump_e, rd_e, alu_src_e, result_src_e);
      end
   endtask

   task automatic test_async_reset();
      set_d(1, 1, 0, 0, 1, 0, 2'b10, 3'b000, 32'hCAFE, 32'h1, 32'h80, 32'h0, 32'h84,
            5'd3, 5'd4, 5'd1);
      step();
      checks++;
      if (jump_e !== 1'b1 || rd1_e !== 32'hCAFE) begin
         errors++; $display("FAIL pre_reset got jump=%b rd1=%h want 1/cafe", jump_e, rd1_e);
      end
      #3 reset = 1'b1;
      #1;
      checks++;
      if (all_e !== '0) begin
         errors++; $display("FAIL async_reset all_e got %h want 0", all_e);
      end
      stall_e = 1'b1; flush_e = 1'b0;
      step();
      stall_e = 1'b0;
      step();
      checks++;
      if (all_e !== '0) begin
         errors++; $display("FAIL reset_held all_e got %h want 0", all_e);
      end
      reset = 1'b0;
      step();
      checks++;
      if (rd1_e !== 32'hCAFE || valid_e !== 1'b1 || rd_e !== 5'd1) begin
         errors++; $display("FAIL post_reset_capture got rd1=%h valid=%b rd=%0d want cafe/1/1",
                            rd1_e, valid_e, rd_e);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         set_d(1, 1, 0, 0, 0, 0, 2'b00, 3'b010, 32'h100 + i, 32'h200 + i, 32'h1000 + 4 * i,
               32'd0, 32'h1004 + 4 * i, 5'(i), 5'(i + 1), 5'(10 + i));
         step();
         checks++;
         if (rd1_e !== 32'h100 + i || rd_e !== 5'(10 + i) || pc_plus4_e !== 32'h1004 + 4 * i ||
             alu_control_e !== 3'b010) begin
            errors++; $display("FAIL b2b_%0d got rd1=%h rd=%0d pc4=%h alu=%b", i, rd1_e, rd_e,
                               pc_plus4_e, alu_control_e);
         end
      end
   endtask

`ifdef ID_EX_PERF_EN
   task automatic test_saturation();
      force dut.bubble_count_e = 32'hFFFF_FFFE;
      #1;
      release dut.bubble_count_e;
      flush_e = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bubble_count_e !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL bubble_saturate cycle %0d got %h want ffffffff", i, bubble_count_e);
         end
      end
      flush_e = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_capture_lw();
      test_stall();
      test_flush_priority();
      test_invalid();
      test_back_to_back();
      test_async_reset();
`ifdef ID_EX_PERF_EN
      test_saturation();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
